keypad_matrix_scanner: RTL and testbench
========================================

# keypad_matrix_scanner

Parametrised matrix-keypad scanner for the charger front panel. Drives one-hot active-low column strobes, synchronises and debounces active-low row returns, and encodes a stable press into a linear key code. Adds press/auto-repeat events and a small event FIFO with a valid/ready handshake, so the amount manager and charge controller can consume keys at their own pace. Decoding key codes into number, START, CLEAR and CONFIRM stays downstream.

## Interface
- ROWS, 4, number of row inputs (2..8)
- COLS, 4, number of column outputs (2..8)
- DEBOUNCE, 15, ticks a press or release must stay stable (1..255)
- REPEAT_DELAY, 500, ticks from accepted press to first repeat event; 0 disables repeat
- REPEAT_RATE, 100, ticks between subsequent repeat events (≥1)
- FIFO_DEPTH, 4, event FIFO entries (power of two, ≥2)
- KW, derived, $clog2(ROWS*COLS), key code width
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-high
- tick  in  1  1 ms enable strobe, one clk wide; all timing counts ticks
- row  in  ROWS  row returns, active-low, asynchronous to clk
- col  out  COLS  column drive, active-low
- ev_valid  out  1  FIFO head valid
- ev_ready  in  1  consumer accepts head
- ev_code  out  KW  key code of head, row_idx*COLS + col_idx
- ev_repeat  out  1  head is an auto-repeat event (0 = initial press)
- key_held  out  1  a debounced key is currently held
- overflow  out  1  sticky; set when an event is dropped because the FIFO is full

## Operation
- row passes through a 2-flop synchroniser before any use. All decisions use the synchronised value; "pressed" means any bit is 0.
- FSM states and transitions (advance only on tick unless noted):
  - IDLE: col all 0. Go to SCAN on a tick with pressed.
  - SCAN: col = one-hot-low, index c, starting at 0. On a tick: if pressed, latch c and the lowest-index low row r, then go to DEBOUNCE. Otherwise increment c. After c = COLS-1 with no hit, return to IDLE.
  - DEBOUNCE: hold the column. Count ticks while the row pattern equals the latched pattern. Any mismatch returns to IDLE. After DEBOUNCE equal ticks, push a press event {code, repeat=0}, set key_held and go to HELD.
  - HELD: hold the column. On the first tick where the latched row reads high, go to RELEASE. If REPEAT_DELAY≠0, push {code, repeat=1} after REPEAT_DELAY ticks, then every REPEAT_RATE ticks.
  - RELEASE: col all 0. Count consecutive not-pressed ticks. Any press resets the count, with no new event. After DEBOUNCE ticks, clear key_held and go to IDLE.
- Multiple simultaneous keys: only the first column hit and the lowest row in it are reported. Other keys are ignored until full release.
- FIFO: push happens in the same cycle as the FSM decision. Pop happens when ev_valid && ev_ready. A push and a pop in the same cycle on a full FIFO are both accepted. A push to a full FIFO with no pop is dropped and sets overflow. overflow clears only on reset.
- Reset at any point: FSM to IDLE, counters 0, FIFO emptied. Outputs: col all 0, ev_valid 0, ev_code 0, ev_repeat 0, key_held 0, overflow 0.

## Timing
- Press-to-event: 2 clk (sync) + up to COLS+1 ticks to detect + DEBOUNCE ticks. The event is visible on ev_valid the clk after the push.
- The FIFO is first-word-fall-through: ev_code and ev_repeat are stable while ev_valid && !ev_ready.
- Repeat events are spaced exactly REPEAT_RATE ticks apart. A release during a repeat wait produces no further events.
- tick held low freezes the FSM and counters; the FIFO still pops.
- Counter widths: each counter is sized to its own parameter. No wrap is allowed; counters saturate at their terminal count.

## Structure
- Package keypad_pkg: state enum (IDLE, SCAN, DEBOUNCE, HELD, RELEASE), event struct {code, repeat}, and the no_press constant generator.
- Sub-module keypad_event_fifo: parameterised FWFT FIFO with the overflow flag, reused by other panel inputs.

## Test plan
- Defaults, press (row 1, col 2) held for 20 ticks -> one event, code 6, repeat 0, key_held 1; after release + 15 ticks, key_held 0.
- 8 ticks of bounce (toggling every 3 ticks) then stable (row 0, col 0) -> no event during bounce; one event code 0 after 15 stable ticks.
- Hold key code 13 for 800 ticks with REPEAT_DELAY 500 and REPEAT_RATE 100 -> events at press, +500, +600 and +700; the last three have repeat 1.
- ev_ready held 0, 5 distinct presses -> 4 events queued and overflow 1; on draining, codes come out in press order.
- Two keys in the same column (rows 1 and 3, col 0) -> only code 4 is reported.
- rst_n pulsed during HELD with 2 events queued -> ev_valid 0, col 4'b0000, key_held 0 within the same cycle; after reset, a release and re-press gives a normal event.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types for the front-panel keypad scanner and its event FIFO.
package keypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } state_t;

  // Wide enough for the largest matrix (8x8 keys).
  localparam int KEY_CODE_MAX_W = 6;

  typedef struct packed {
    logic [KEY_CODE_MAX_W-1:0] code;
    logic                      is_repeat;
  } key_event_t;

  // All-rows-high pattern for a matrix with the given number of rows.
  function automatic logic [7:0] no_press(input int rows);
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < rows) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// First-word-fall-through event FIFO with a sticky overflow flag.
module keypad_event_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] head,
  output logic         overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          overflow_reg;
  logic          full;
  logic          do_pop;
  logic          do_push;

  assign full     = (count_reg == FULL_COUNT);
  assign valid    = (count_reg != '0);
  assign do_pop   = valid && pop;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign head     = valid ? mem[rd_ptr_reg] : '0;
  assign overflow = overflow_reg;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (push && full && !do_pop) overflow_reg <= 1'b1;
    end
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Matrix keypad scanner: column strobing, row debounce, press/auto-repeat
// events queued in a small FWFT FIFO for the panel consumers.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int DEBOUNCE     = 15,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100,
  parameter int FIFO_DEPTH   = 4,
  localparam int KW          = $clog2(ROWS*COLS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick,
  input  logic [ROWS-1:0] row,
  output logic [COLS-1:0] col,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic [KW-1:0]   ev_code,
  output logic            ev_repeat,
  output logic            key_held,
  output logic            overflow
);

  localparam int CW      = $clog2(COLS);
  localparam int RIW     = $clog2(ROWS);
  localparam int DW      = $clog2(DEBOUNCE + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int PW      = $clog2(RPT_MAX + 1);

  localparam logic [ROWS-1:0] NO_PRESS   = ROWS'(no_press(ROWS));
  localparam logic [DW-1:0]   DB_LAST    = DW'(DEBOUNCE - 1);
  localparam logic [PW-1:0]   DELAY_LAST = PW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [PW-1:0]   RATE_LAST  = PW'(REPEAT_RATE - 1);
  localparam logic [CW-1:0]   COL_LAST   = CW'(COLS - 1);
  localparam logic            RPT_EN     = (REPEAT_DELAY != 0);

  state_t          state_reg;
  logic [ROWS-1:0] row_s1_reg;
  logic [ROWS-1:0] row_s2_reg;
  logic [ROWS-1:0] row_pat_reg;
  logic [CW-1:0]   col_idx_reg;
  logic [RIW-1:0]  row_idx_reg;
  logic [DW-1:0]   db_cnt_reg;
  logic [PW-1:0]   rpt_cnt_reg;
  logic            rpt_first_reg;
  logic [COLS-1:0] col_reg;
  logic            key_held_reg;

  logic            pressed;
  logic            row_match;
  logic            latched_high;
  logic [PW-1:0]   rpt_last;
  logic [RIW-1:0]  low_row;
  logic [KW-1:0]   key_code;
  logic            push_press;
  logic            push_rpt;
  key_event_t      ev_in;
  key_event_t      ev_head;

  function automatic logic [COLS-1:0] col_drive(input logic [CW-1:0] c);
    return ~(COLS'(1) << c);
  endfunction

  assign pressed      = (row_s2_reg != NO_PRESS);
  assign row_match    = (row_s2_reg == row_pat_reg);
  assign latched_high = row_s2_reg[row_idx_reg];
  assign rpt_last     = rpt_first_reg ? DELAY_LAST : RATE_LAST;
  assign key_code     = KW'(int'(row_idx_reg) * COLS + int'(col_idx_reg));

  always_comb begin
    low_row = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (!row_s2_reg[i]) low_row = RIW'(i);
    end
  end

  // Pushes are decided combinationally so they land on the same edge as the FSM step.
  assign push_press = tick && (state_reg == ST_DEBOUNCE) && row_match && (db_cnt_reg == DB_LAST);
  assign push_rpt   = RPT_EN && tick && (state_reg == ST_HELD) && !latched_high &&
                      (rpt_cnt_reg == rpt_last);

  always_comb begin
    ev_in           = '0;
    ev_in.code      = KEY_CODE_MAX_W'(key_code);
    ev_in.is_repeat = push_rpt;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      row_s1_reg    <= NO_PRESS;
      row_s2_reg    <= NO_PRESS;
      state_reg     <= ST_IDLE;
      row_pat_reg   <= NO_PRESS;
      col_idx_reg   <= '0;
      row_idx_reg   <= '0;
      db_cnt_reg    <= '0;
      rpt_cnt_reg   <= '0;
      rpt_first_reg <= 1'b1;
      col_reg       <= '0;
      key_held_reg  <= 1'b0;
    end else begin
      row_s1_reg <= row;
      row_s2_reg <= row_s1_reg;
      if (tick) begin
        unique case (state_reg)
          ST_IDLE: begin
            if (pressed) begin
              state_reg   <= ST_SCAN;
              col_idx_reg <= '0;
              col_reg     <= col_drive('0);
            end
          end
          ST_SCAN: begin
            if (pressed) begin
              row_idx_reg <= low_row;
              row_pat_reg <= row_s2_reg;
              db_cnt_reg  <= '0;
              state_reg   <= ST_DEBOUNCE;
            end else if (col_idx_reg == COL_LAST) begin
              state_reg <= ST_IDLE;
              col_reg   <= '0;
            end else begin
              col_idx_reg <= col_idx_reg + 1'b1;
              col_reg     <= col_drive(CW'(col_idx_reg + 1'b1));
            end
          end
          ST_DEBOUNCE: begin
            if (!row_match) begin
              state_reg <= ST_IDLE;
              col_reg   <= '0;
            end else if (db_cnt_reg == DB_LAST) begin
              state_reg     <= ST_HELD;
              key_held_reg  <= 1'b1;
              rpt_cnt_reg   <= '0;
              rpt_first_reg <= 1'b1;
            end else begin
              db_cnt_reg <= db_cnt_reg + 1'b1;
            end
          end
          ST_HELD: begin
            // Release is judged on the latched row only; other keys are ignored.
            if (latched_high) begin
              state_reg  <= ST_RELEASE;
              col_reg    <= '0;
              db_cnt_reg <= '0;
            end else if (RPT_EN) begin
              if (rpt_cnt_reg == rpt_last) begin
                rpt_cnt_reg   <= '0;
                rpt_first_reg <= 1'b0;
              end else begin
                rpt_cnt_reg <= rpt_cnt_reg + 1'b1;
              end
            end
          end
          ST_RELEASE: begin
            if (pressed) begin
              db_cnt_reg <= '0;
            end else if (db_cnt_reg == DB_LAST) begin
              state_reg    <= ST_IDLE;
              key_held_reg <= 1'b0;
            end else begin
              db_cnt_reg <= db_cnt_reg + 1'b1;
            end
          end
          default: begin
            state_reg <= ST_IDLE;
            col_reg   <= '0;
          end
        endcase
      end
    end
  end

  keypad_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(key_event_t))
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_press || push_rpt),
    .push_data (ev_in),
    .pop       (ev_ready),
    .valid     (ev_valid),
    .head      (ev_head),
    .overflow  (overflow)
  );

  assign col       = col_reg;
  assign key_held  = key_held_reg;
  assign ev_code   = KW'(ev_head.code);
  assign ev_repeat = ev_head.is_repeat;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner: a 4x4 key matrix model drives the rows and a
// tick-level reference predicts every event code, flag and arrival tick.
module tb_keypad_matrix_scanner;

  localparam int ROWS         = 4;
  localparam int COLS         = 4;
  localparam int NK           = ROWS * COLS;
  localparam int DEBOUNCE     = 15;
  localparam int REPEAT_DELAY = 500;
  localparam int REPEAT_RATE  = 100;
  localparam int FIFO_DEPTH   = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            tick = 1'b0;
  logic            ev_ready = 1'b0;
  logic [ROWS-1:0] row;
  logic [COLS-1:0] col;
  logic            ev_valid;
  logic [3:0]      ev_code;
  logic            ev_repeat;
  logic            key_held;
  logic            overflow;
  logic [NK-1:0]   keys = '0;

  int tick_idx = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int code;
    bit rpt;
    int t;
  } ev_t;

  ev_t exp_q[$];
  ev_t got_q[$];

  always #5 clk = ~clk;

  // Physical matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (keys[r*COLS+c] && !col[c]) row[r] = 1'b0;
  end

  keypad_matrix_scanner #(
    .ROWS(ROWS), .COLS(COLS), .DEBOUNCE(DEBOUNCE), .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE(REPEAT_RATE), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .row(row), .col(col),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_repeat(ev_repeat),
    .key_held(key_held), .overflow(overflow)
  );

  always @(negedge clk) begin
    if (!rst_n && ev_valid && ev_ready)
      got_q.push_back('{int'(ev_code), ev_repeat, tick_idx});
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish, checks %0d", checks);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      repeat (3) @(negedge clk);
      tick = 1'b1;
      tick_idx++;
      @(negedge clk);
      tick = 1'b0;
    end
  endtask

  // Keys in mask pressed just after tick x0 and released just after tick x.
  // The reported key is the lowest row in the lowest pressed column; it is seen
  // one tick after leaving idle plus one tick per column scanned, then debounced.
  function automatic bit model(input logic [NK-1:0] mask, input int x0, input int x);
    int c_hit = -1;
    int r_hit = -1;
    int p;
    int code;
    for (int c = 0; c < COLS; c++)
      if (c_hit < 0)
        for (int r = 0; r < ROWS; r++)
          if (mask[r*COLS+c] && r_hit < 0) begin
            c_hit = c;
            r_hit = r;
          end
    if (c_hit < 0) return 1'b0;
    p = x0 + 2 + c_hit + DEBOUNCE;
    if (p > x) return 1'b0;
    code = r_hit * COLS + c_hit;
    exp_q.push_back('{code, 1'b0, p});
    if (REPEAT_DELAY != 0)
      for (int t = p + REPEAT_DELAY; t <= x; t += REPEAT_RATE)
        exp_q.push_back('{code, 1'b1, t});
    return 1'b1;
  endfunction

  task automatic compare_events(input string tag, input bit with_time);
    check({tag, ".count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s.code%0d", tag, i), got_q[i].code, exp_q[i].code);
      check($sformatf("%s.rpt%0d", tag, i), got_q[i].rpt, exp_q[i].rpt);
      if (with_time) check($sformatf("%s.tick%0d", tag, i), got_q[i].t, exp_q[i].t);
    end
    $display("%s: %0d events observed, %0d expected", tag, got_q.size(), exp_q.size());
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic press_cycle(input string tag, input logic [NK-1:0] mask, input int hold,
                             input bit with_time);
    int x0;
    bit held;
    x0 = tick_idx;
    keys = mask;
    do_ticks(hold);
    held = model(mask, x0, tick_idx);
    check({tag, ".held"}, key_held, held);
    keys = '0;
    do_ticks(20);
    check({tag, ".released"}, key_held, 0);
    if (ev_ready) compare_events(tag, with_time);
  endtask

  initial begin
    int s;
    bit held;
    bit used [NK];
    int codes [5];
    logic [NK-1:0] m;

    repeat (3) @(negedge clk);
    check("rst.col", col, 0);
    check("rst.ev_valid", ev_valid, 0);
    check("rst.ev_code", ev_code, 0);
    check("rst.ev_repeat", ev_repeat, 0);
    check("rst.key_held", key_held, 0);
    check("rst.overflow", overflow, 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst.col", col, 0);
    check("post_rst.ev_valid", ev_valid, 0);
    ev_ready = 1'b1;

    // Row 1, column 2 -> code 6.
    press_cycle("basic", NK'(1) << 6, 20, 1'b1);

    // Bounce on key 0, then a stable press starting after tick s.
    keys = NK'(1);
    do_ticks(3);
    keys = '0;
    do_ticks(3);
    keys = NK'(1);
    s = tick_idx;
    do_ticks(2);
    check("bounce.quiet", got_q.size(), 0);
    do_ticks(38);
    held = model(NK'(1), s, tick_idx);
    check("bounce.held", key_held, held);
    keys = '0;
    do_ticks(20);
    compare_events("bounce", 1'b1);

    // Rows 1 and 3 of column 0: only code 4 reported.
    press_cycle("same_col", (NK'(1) << 4) | (NK'(1) << 12), 20, 1'b1);

    for (int it = 0; it < 8; it++) begin
      m = '0;
      m[$urandom_range(NK-1, 0)] = 1'b1;
      if ($urandom_range(1, 0) == 1) m[$urandom_range(NK-1, 0)] = 1'b1;
      press_cycle($sformatf("rand%0d", it), m, int'($urandom_range(60, 4)), 1'b1);
    end

    press_cycle("repeat", NK'(1) << 13, 800, 1'b1);

    // Back-pressure: five distinct presses into a four-entry FIFO.
    ev_ready = 1'b0;
    foreach (used[i]) used[i] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      do codes[i] = int'($urandom_range(NK-1, 0)); while (used[codes[i]]);
      used[codes[i]] = 1'b1;
      press_cycle($sformatf("ovf%0d", i), NK'(1) << codes[i], 24, 1'b0);
    end
    while (exp_q.size() > FIFO_DEPTH) void'(exp_q.pop_back());
    check("ovf.valid", ev_valid, 1);
    check("ovf.flag", overflow, 1);
    check("ovf.head_code", ev_code, codes[0]);
    check("ovf.head_rpt", ev_repeat, 0);
    ev_ready = 1'b1;
    repeat (FIFO_DEPTH + 2) @(negedge clk);
    compare_events("ovf_drain", 1'b0);
    check("ovf.sticky", overflow, 1);

    // Reset while a key is held and two events are queued.
    ev_ready = 1'b0;
    press_cycle("rst_a", NK'(1) << 5, 24, 1'b0);
    keys = NK'(1) << 10;
    do_ticks(24);
    check("rst.pre_valid", ev_valid, 1);
    check("rst.pre_held", key_held, 1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst.async_valid", ev_valid, 0);
    check("rst.async_col", col, 0);
    check("rst.async_held", key_held, 0);
    check("rst.async_code", ev_code, 0);
    check("rst.async_ovf", overflow, 0);
    @(negedge clk);
    rst_n = 1'b0;
    keys = '0;
    exp_q.delete();
    got_q.delete();
    ev_ready = 1'b1;
    do_ticks(20);
    compare_events("rst.flushed", 1'b1);
    press_cycle("rst.again", NK'(1) << 10, 24, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
